freelist: RTL and testbench
===========================

# freelist

Physical-register free list for the 4-wide rename stage. A circular buffer of free physical tags: it presents up to four tags per cycle to rename, pops the ones rename consumes, and accepts up to four old physical tags per cycle released by commit. It sits directly upstream of rename and downstream of the commit/ROB logic.

## Interface
- WIDTH, 7, physical tag width; physical register file has 2**WIDTH entries
- NARCH, 32, architectural registers; tags 0..NARCH-1 are mapped at reset and never start in the list
- DEPTH, 2**WIDTH-NARCH (96), list capacity
- Clocking: one clock; reset is asynchronous and active-high.
- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  asynchronous active-high reset
- i_en  in  1  global advance enable from rename; 0 = no pop this cycle
- i_rden  in  4  per-slot allocate request from rename (its o_enfreelist)
- o_freelist  out  4*WIDTH  steered tags, slot k at bits [k*WIDTH +: WIDTH]
- o_stall  out  1  not enough free tags for this cycle's request
- i_wren  in  4  per-slot release valid from commit
- i_wrtag  in  4*WIDTH  released (old) tags, slot k at [k*WIDTH +: WIDTH]
- o_count  out  WIDTH  number of free tags held
- o_overflow  out  1  sticky: a release was dropped because the list was full

## Operation
- State: mem[DEPTH], head, tail (mod DEPTH), count (0..DEPTH), overflow flag.
- Reset: mem[i] = NARCH+i, head = 0, tail = 0, count = DEPTH, overflow = 0. Outputs at reset: o_freelist = {35,34,33,32}, o_count = 96, o_stall = 0, o_overflow = 0.
- Allocate steering (combinational): npop = popcount(i_rden); slot k gets mem[(head + popcount(i_rden[k-1:0])) mod DEPTH]. Slots with i_rden[k]=0 show the same tag as the next requesting slot; rename ignores them.
- o_stall = (npop > count). Pop occurs when i_en & !o_stall; head += npop, count -= npop. On stall nothing is popped; rename holds.
- Release: npush = popcount(i_wren); slot k writes i_wrtag slot k to mem[(tail + popcount(i_wren[k-1:0])) mod DEPTH]; tail += npush. Releases are never stalled.
- Simultaneous pop and push: count_next = count - npop_eff + npush. Full check uses count - npop_eff: pushes beyond DEPTH are dropped (highest slots first), tail advances only by accepted pushes, overflow set until reset.
- No same-cycle bypass: a tag pushed in cycle n is poppable from cycle n+1 at the earliest.
- Wrap-around: all index arithmetic mod DEPTH (non-power-of-2: compare-and-subtract, operands < 2*DEPTH).
- Reset mid-operation restores the reset image immediately, regardless of in-flight requests.

## Timing
- o_freelist, o_stall: combinational from registered head/count/mem and i_rden; no dependence on i_wren/i_wrtag.
- o_count, o_overflow: registered, update one edge after the event.
- Pop latency 0 (tags valid in the request cycle); push-to-visible latency 1 cycle.

## Structure
- Shared package: WIDTH, NARCH, DEPTH, rename width (4) constant, tag typedef.
- Sub-module: pcnt4 — 4-bit popcount plus prefix counts (outputs count of bits below each slot); instantiated once for i_rden and once for i_wren.
- mem as register array with per-slot write ports; no SRAM.

## Test plan
- Reset, i_rden=4'hF, i_en=1 -> o_freelist={35,34,33,32}; next cycle {39,38,37,36}, o_count 96->92.
- i_rden=4'b1010 from reset -> slot1=32, slot3=33; head advances 2, o_count=94.
- Drain to count=2, request 4'hF -> o_stall=1, no pop, o_count stays 2; request 4'b0011 -> pops, o_count=0.
- Count=0, i_wren=4'b0101 with tags 5 and 9 in same cycle as i_rden=4'h1 -> o_stall=1 (no bypass); next cycle slot0 shows 5, o_count=2.
- Pop and push across index 95->0 boundary -> tags returned in FIFO order after wrap, o_count consistent.
- At count=96, push 4'b0011 -> both dropped, o_overflow=1 sticky; assert i_rst mid-cycle -> all outputs at reset values without waiting for an edge.

Source files
------------

// File: rtl/freelist_pkg.sv
// Shared constants, tag type and modular index helper for the physical-register free list.
package freelist_pkg;

    localparam int WIDTH = 7;
    localparam int NARCH = 32;
    localparam int DEPTH = (1 << WIDTH) - NARCH;
    localparam int RW    = 4;

    localparam logic [WIDTH:0] DEPTH_X = (WIDTH+1)'(DEPTH);

    typedef logic [WIDTH-1:0] tag_t;

    // Add a small offset (0..7) to a ring index and wrap modulo DEPTH.
    // DEPTH is not a power of two, so a single compare-and-subtract is
    // used; the sum is always below 2*DEPTH.
    function automatic tag_t idx_add(input tag_t base, input logic [2:0] off);
        logic [WIDTH:0] sum;
        sum = {1'b0, base} + {{(WIDTH-2){1'b0}}, off};
        if (sum >= DEPTH_X) begin
            sum = sum - DEPTH_X;
        end
        return sum[WIDTH-1:0];
    endfunction

endpackage

// File: rtl/freelist_pcnt4.sv
// 4-bit population count plus per-slot prefix counts (number of set bits
// strictly below each slot). Slot k prefix is at o_prefix[2*k +: 2].
module freelist_pcnt4 (
    input  logic [3:0] i_bits,
    output logic [2:0] o_total,
    output logic [7:0] o_prefix
);

    logic [1:0] w_b0;
    logic [1:0] w_b1;
    logic [1:0] w_b2;
    logic [2:0] w_b3;

    // Zero-extend each bit and form the running sums.
    always_comb begin
        w_b0     = {1'b0, i_bits[0]};
        w_b1     = {1'b0, i_bits[1]};
        w_b2     = {1'b0, i_bits[2]};
        w_b3     = {2'b00, i_bits[3]};
        o_prefix = {w_b0 + w_b1 + w_b2, w_b0 + w_b1, w_b0, 2'b00};
        o_total  = {1'b0, o_prefix[7:6]} + {1'b0, w_b2} + w_b3 - {2'b00, i_bits[2]};
    end

endmodule

// File: rtl/freelist.sv
// Physical-register free list: circular buffer of free tags feeding the
// 4-wide rename stage, refilled by up to four commit releases per cycle.
module freelist
    import freelist_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [RW-1:0]         i_rden,
    output logic [RW*WIDTH-1:0]   o_freelist,
    output logic                  o_stall,
    input  logic [RW-1:0]         i_wren,
    input  logic [RW*WIDTH-1:0]   i_wrtag,
    output logic [WIDTH-1:0]      o_count,
    output logic                  o_overflow
);

    tag_t               r_mem [DEPTH];
    tag_t               r_head;
    tag_t               r_tail;
    logic [WIDTH-1:0]   r_count;
    logic               r_ovf;

    logic [2:0]         w_rd_tot;
    logic [7:0]         w_rd_pre;
    logic [2:0]         w_wr_tot;
    logic [7:0]         w_wr_pre;

    tag_t               w_ridx [RW];
    tag_t               w_widx [RW];
    logic [RW-1:0]      w_wacc;
    logic               w_pop;
    logic [2:0]         w_npop_eff;
    logic [2:0]         w_nacc;
    logic [WIDTH-1:0]   w_room;
    logic               w_drop;

    freelist_pcnt4 u_pcnt_rd (
        .i_bits   (i_rden),
        .o_total  (w_rd_tot),
        .o_prefix (w_rd_pre)
    );

    freelist_pcnt4 u_pcnt_wr (
        .i_bits   (i_wren),
        .o_total  (w_wr_tot),
        .o_prefix (w_wr_pre)
    );

    // Allocate steering: each slot reads the entry at head plus the number
    // of requesting slots below it, straight from the registered array.
    always_comb begin
        o_freelist = '0;
        for (int k = 0; k < RW; k++) begin
            w_ridx[k] = idx_add(r_head, {1'b0, w_rd_pre[2*k +: 2]});
            o_freelist[k*WIDTH +: WIDTH] = r_mem[w_ridx[k]];
        end
    end

    // Stall, effective pop, and how many releases fit after this cycle's pop.
    // Releases are accepted lowest slot first, so the highest ones drop.
    always_comb begin
        o_stall    = ({{(WIDTH-3){1'b0}}, w_rd_tot} > r_count);
        w_pop      = i_en & ~o_stall;
        w_npop_eff = w_pop ? w_rd_tot : 3'd0;
        w_room     = WIDTH'(DEPTH) - (r_count - {{(WIDTH-3){1'b0}}, w_npop_eff});
        w_nacc     = 3'd0;
        for (int k = 0; k < RW; k++) begin
            w_widx[k] = idx_add(r_tail, {1'b0, w_wr_pre[2*k +: 2]});
            w_wacc[k] = i_wren[k] && ({{(WIDTH-2){1'b0}}, w_wr_pre[2*k +: 2]} < w_room);
            w_nacc    = w_nacc + {2'b00, w_wacc[k]};
        end
        w_drop = |(i_wren & ~w_wacc);
    end

    // Control state: head/tail pointers, occupancy and sticky overflow.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= WIDTH'(DEPTH);
            r_ovf   <= 1'b0;
        end else begin
            r_head  <= idx_add(r_head, w_npop_eff);
            r_tail  <= idx_add(r_tail, w_nacc);
            r_count <= r_count - {{(WIDTH-3){1'b0}}, w_npop_eff}
                               + {{(WIDTH-3){1'b0}}, w_nacc};
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Tag storage: reset image holds every non-architectural tag in order;
    // accepted releases write at consecutive tail positions.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= WIDTH'(NARCH + i);
            end
        end else begin
            for (int k = 0; k < RW; k++) begin
                if (w_wacc[k]) begin
                    r_mem[w_widx[k]] <= i_wrtag[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign o_count    = r_count;
    assign o_overflow = r_ovf;

    wire unused_wr_tot = ^w_wr_tot;

endmodule

// File: tb/tb_freelist.sv
// Testbench for freelist: randomized and directed stimulus against a
// queue-based reference model, with a scoreboard monitor.
module tb_freelist;
    import freelist_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic [3:0]           rden;
    logic [3:0]           wren;
    logic [4*WIDTH-1:0]   wrtag;
    logic [4*WIDTH-1:0]   fl;
    logic                 stall;
    logic [WIDTH-1:0]     cnt;
    logic                 ovf;

    freelist dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_rden     (rden),
        .o_freelist (fl),
        .o_stall    (stall),
        .i_wren     (wren),
        .i_wrtag    (wrtag),
        .o_count    (cnt),
        .o_overflow (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]         mask;
        logic [4*WIDTH-1:0] tags;
        logic               stall;
        int                 count;
        logic               ovf;
    } exp_t;

    exp_t exp_q[$];
    int   model_q[$];
    bit   model_ovf;
    int   checks   = 0;
    int   failures = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endfunction

    function automatic void model_reset();
        model_q.delete();
        for (int i = 0; i < DEPTH; i++) model_q.push_back(NARCH + i);
        model_ovf = 1'b0;
    endfunction

    // One cycle of stimulus: drive at negedge, record expectation, advance model.
    task automatic cycle(input logic e, input logic [3:0] rd, input logic [3:0] wr,
                         input logic [4*WIDTH-1:0] tg);
        exp_t x;
        int   p;
        int   npop;
        @(negedge clk);
        en = e; rden = rd; wren = wr; wrtag = tg;
        npop   = $countones(rd);
        x.mask = '0;
        x.tags = '0;
        p      = 0;
        for (int k = 0; k < 4; k++) begin
            if (rd[k]) begin
                if (p < model_q.size()) begin
                    x.mask[k] = 1'b1;
                    x.tags[k*WIDTH +: WIDTH] = WIDTH'(model_q[p]);
                end
                p++;
            end
        end
        x.stall = (npop > model_q.size());
        x.count = model_q.size();
        x.ovf   = model_ovf;
        exp_q.push_back(x);
        if (e && !x.stall) begin
            repeat (npop) void'(model_q.pop_front());
        end
        for (int k = 0; k < 4; k++) begin
            if (wr[k]) begin
                if (model_q.size() < DEPTH) model_q.push_back(int'(tg[k*WIDTH +: WIDTH]));
                else model_ovf = 1'b1;
            end
        end
    endtask

    // Assert reset between edges with busy inputs; outputs must snap to the reset image.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1; en = 1'b1; rden = 4'hF; wren = 4'hF; wrtag = {$urandom, $urandom};
        #1;
        chk("rst_count", cnt, DEPTH);
        chk("rst_ovf", ovf, 0);
        chk("rst_stall", stall, 0);
        chk("rst_freelist", fl, {7'd35, 7'd34, 7'd33, 7'd32});
        model_reset();
        @(negedge clk);
        rst = 1'b0; en = 1'b0; rden = '0; wren = '0; wrtag = '0;
    endtask

    // Scoreboard monitor: compare every presented cycle against the queued expectation.
    always begin : mon
        exp_t x;
        @(negedge clk);
        #2;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("stall", stall, x.stall);
            chk("count", cnt, x.count);
            chk("overflow", ovf, x.ovf);
            for (int k = 0; k < 4; k++) begin
                if (x.mask[k]) chk("slot_tag", fl[k*WIDTH +: WIDTH], x.tags[k*WIDTH +: WIDTH]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]         r_rd;
        logic [3:0]         r_wr;
        logic [4*WIDTH-1:0] r_tg;
        bit                 push_heavy;
        rst = 1'b1; en = 1'b0; rden = '0; wren = '0; wrtag = '0;
        model_reset();
        do_reset();

        // Full-width allocation from reset, then the next group.
        cycle(1'b1, 4'hF, 4'h0, '0);
        cycle(1'b1, 4'hF, 4'h0, '0);
        cycle(1'b0, 4'h0, 4'h0, '0);

        // Sparse request steering.
        do_reset();
        cycle(1'b1, 4'b1010, 4'h0, '0);
        cycle(1'b0, 4'h0, 4'h0, '0);

        // Drain to two, stall on four, then take the last two; push with no bypass.
        do_reset();
        repeat (23) cycle(1'b1, 4'hF, 4'h0, '0);
        cycle(1'b1, 4'b0011, 4'h0, '0);
        cycle(1'b1, 4'hF, 4'h0, '0);
        cycle(1'b1, 4'b0011, 4'h0, '0);
        cycle(1'b1, 4'h1, 4'b0101, {7'd0, 7'd9, 7'd0, 7'd5});
        cycle(1'b1, 4'h1, 4'h0, '0);
        cycle(1'b0, 4'h0, 4'h0, '0);

        // Wrap across the 95 -> 0 boundary in the middle of a pop group.
        do_reset();
        cycle(1'b1, 4'b0011, 4'h0, '0);
        cycle(1'b0, 4'h0, 4'b0011, {7'd0, 7'd0, 7'd101, 7'd100});
        repeat (24) cycle(1'b1, 4'hF, 4'h0, '0);
        cycle(1'b0, 4'h0, 4'hF, {7'd44, 7'd43, 7'd42, 7'd41});
        cycle(1'b1, 4'hF, 4'h0, '0);

        // Release into a full list: dropped, sticky overflow.
        do_reset();
        cycle(1'b0, 4'h0, 4'b0011, {7'd0, 7'd0, 7'd3, 7'd2});
        cycle(1'b0, 4'h0, 4'h0, '0);
        cycle(1'b1, 4'h1, 4'h0, '0);
        cycle(1'b0, 4'h0, 4'h0, '0);
        do_reset();
        cycle(1'b0, 4'h0, 4'h0, '0);

        // Randomized traffic alternating push-heavy and pop-heavy phases.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            push_heavy = ((i / 150) % 2) == 1;
            r_rd = 4'($urandom);
            for (int k = 0; k < 4; k++) begin
                r_wr[k] = push_heavy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            end
            r_tg = {$urandom, $urandom};
            cycle($urandom_range(0, 3) != 0, r_rd, r_wr, r_tg);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
